// File: rtl/xor_frame_parity.sv
`default_nettype none
// ============================================================================
// Module      : xor_frame_parity
// Description : Serial frame-parity accumulator placed behind the XOR cell.
//               Folds FRAME_LEN accepted bits into a running XOR and presents
//               one even-parity result per frame on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FRAME_LEN   bits per frame, legal range 2..256 (default 8)
//   CNT_W       $clog2(FRAME_LEN), width of the bit counter (derived)
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear, abandons the current frame
//   in_valid    in_bit is valid this cycle
//   in_bit      serial data bit
//   in_ready    block can accept in_bit (decoded from state)
//   out_valid   out_parity holds a completed frame result
//   out_ready   downstream accepts the result
//   out_parity  XOR of all FRAME_LEN bits of the completed frame
//   bit_cnt     bits accepted so far in the current frame
//   ones_cnt    number of 1 bits in the completed frame (optional)
// Configuration
//   XOR_FRAME_PARITY_ONES_EN  when defined, adds the ones_cnt output and
//                             its counter; otherwise both are absent.
// ============================================================================
module xor_frame_parity #(
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] bit_cnt
`ifdef XOR_FRAME_PARITY_ONES_EN
  ,
  output logic [CNT_W:0]   ones_cnt
`endif
);

  // Index of the final bit of a frame; the counter wraps only from here.
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_q, parity_d;
  logic             w_accept;
  logic             w_last;

`ifdef XOR_FRAME_PARITY_ONES_EN
  // Running ones count of the current frame and the published frame count.
  // CNT_W+1 bits hold FRAME_LEN itself (an all-ones frame).
  logic [CNT_W:0]   ones_acc_q, ones_acc_d;
  logic [CNT_W:0]   ones_q, ones_d;
  logic [CNT_W:0]   w_bit_ext;
`endif

  // A bit is only looked at when it is actually accepted, so an undriven
  // in_bit while in_valid is low never reaches the accumulator.
  assign w_accept = (state_q == ST_ACCUM) && in_valid;
  assign w_last   = (cnt_q == C_LAST_IDX);

`ifdef XOR_FRAME_PARITY_ONES_EN
  assign w_bit_ext = {{CNT_W{1'b0}}, in_bit};
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. clr outranks every handshake.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    parity_d    = parity_q;
`ifdef XOR_FRAME_PARITY_ONES_EN
    ones_acc_d  = ones_acc_q;
    ones_d      = ones_q;
`endif

    if (clr) begin
      // Drops any partial frame and any pending result; a bit offered in
      // this cycle is discarded. out_parity keeps its last value, which is
      // harmless because out_valid is low.
      state_d     = ST_ACCUM;
      acc_d       = 1'b0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
`ifdef XOR_FRAME_PARITY_ONES_EN
      ones_acc_d  = '0;
      ones_d      = '0;
`endif
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              // Publish the frame and restart the accumulator in one step.
              parity_d    = acc_q ^ in_bit;
              out_valid_d = 1'b1;
              acc_d       = 1'b0;
              cnt_d       = '0;
              state_d     = ST_HOLD;
`ifdef XOR_FRAME_PARITY_ONES_EN
              ones_d      = ones_acc_q + w_bit_ext;
              ones_acc_d  = '0;
`endif
            end else begin
              acc_d = acc_q ^ in_bit;
              cnt_d = cnt_q + CNT_W'(1);
`ifdef XOR_FRAME_PARITY_ONES_EN
              ones_acc_d = ones_acc_q + w_bit_ext;
`endif
            end
          end
        end
        ST_HOLD: begin
          // Result stays frozen until the downstream takes it.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      parity_q    <= 1'b0;
`ifdef XOR_FRAME_PARITY_ONES_EN
      ones_acc_q  <= '0;
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      parity_q    <= parity_d;
`ifdef XOR_FRAME_PARITY_ONES_EN
      ones_acc_q  <= ones_acc_d;
      ones_q      <= ones_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: flops or a pure decode of the state register.
  // --------------------------------------------------------------------------
  assign in_ready   = (state_q == ST_ACCUM);
  assign out_valid  = out_valid_q;
  assign out_parity = parity_q;
  assign bit_cnt    = cnt_q;

`ifdef XOR_FRAME_PARITY_ONES_EN
  assign ones_cnt = ones_q;
`else
  // Ones counting is compiled out; no extra port or storage exists.
`endif

endmodule
`default_nettype wire
